// File: rtl/nco_pkg.sv
// nco_bank shared definitions.
// Opcodes and FSM state encoding.
package nco_pkg;

  localparam logic [2:0] OP_WR_FTW    = 3'd0;
  localparam logic [2:0] OP_WR_DFTW   = 3'd1;
  localparam logic [2:0] OP_Z_CORR    = 3'd2;
  localparam logic [2:0] OP_PHASE_SET = 3'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SYNC = 1'b1
  } state_t;

endpackage

// File: rtl/nco_bank_if.sv
// nco_bank command port.
// Sequencer drives master, bank is slave.
interface nco_bank_if #(
  parameter int N        = 22,
  parameter int CH_WIDTH = 2
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [CH_WIDTH-1:0] cmd_ch;
  logic [N-1:0]        cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_ch,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_ch,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator,
// FTW ramp, virtual-Z and phase load.
module nco_channel #(
  parameter int N  = 22,
  parameter int ZW = 12,
  parameter int DW = 12,
  parameter int OW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_sync,
  input  logic          run,
  input  logic          wr_ftw,
  input  logic          wr_dftw,
  input  logic          z_corr,
  input  logic          ph_set,
  input  logic [N-1:0]  data,
  output logic [OW-1:0] phase_msb
);

  logic [N-1:0]         ftw_base;
  logic [N-1:0]         ftw_cur;
  logic [N-1:0]         phase;
  logic signed [DW-1:0] dftw;
  logic signed [ZW-1:0] z;
  logic [N-1:0]         z_add;
  logic [N-1:0]         adv;
  logic [N-1:0]         step_ext;

  assign z        = data[ZW-1:0];
  // z is a fraction of a turn aligned to the phase MSBs
  assign z_add    = z_corr ? (N'(z) << (N - ZW)) : '0;
  assign adv      = run ? ftw_cur : '0;
  assign step_ext = N'(dftw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ftw_base <= '0;
      ftw_cur  <= '0;
      dftw     <= '0;
      phase    <= '0;
    end else if (load_sync) begin
      phase   <= '0;
      ftw_cur <= ftw_base;
    end else begin
      if (ph_set)
        phase <= data;
      else
        phase <= phase + adv + z_add;
      if (wr_ftw) begin
        ftw_base <= data;
        ftw_cur  <= data;
      end else if (run) begin
        ftw_cur <= ftw_cur + step_ext;
      end
      if (wr_dftw)
        dftw <= data[DW-1:0];
    end
  end

  assign phase_msb = phase[N-1 -: OW];

endmodule

// File: rtl/nco_bank.sv
// Multi-channel NCO bank: sync FSM,
// command decode and output packing.
module nco_bank
  import nco_pkg::*;
#(
  parameter int N            = 22,
  parameter int NUM_CH       = 4,
  parameter int Z_CORR_WIDTH = 12,
  parameter int DFTW_WIDTH   = 12,
  parameter int OUTPUT_WIDTH = 10,
  localparam int CH_WIDTH    = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  nco_bank_if.slave                      cmd,
  input  logic [NUM_CH-1:0]              run,
  input  logic                           sync,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] phase_out,
  output logic [NUM_CH-1:0]              phase_valid
);

  state_t state;
  logic   accept;
  logic   op_ftw;
  logic   op_dftw;
  logic   op_z;
  logic   op_set;

  assign cmd.cmd_ready = (state == ST_IDLE) && !sync;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      phase_valid <= '0;
    end else begin
      unique case (state)
        ST_IDLE: state <= sync ? ST_SYNC : ST_IDLE;
        ST_SYNC: state <= sync ? ST_SYNC : ST_IDLE;
      endcase
      phase_valid <= run &
        {NUM_CH{(state == ST_IDLE) && !sync}};
    end
  end

  always_comb begin
    op_ftw  = 1'b0;
    op_dftw = 1'b0;
    op_z    = 1'b0;
    op_set  = 1'b0;
    if (accept) begin
      unique case (1'b1)
        cmd.cmd_op == OP_WR_FTW:    op_ftw  = 1'b1;
        cmd.cmd_op == OP_WR_DFTW:   op_dftw = 1'b1;
        cmd.cmd_op == OP_Z_CORR:    op_z    = 1'b1;
        cmd.cmd_op == OP_PHASE_SET: op_set  = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = (cmd.cmd_ch == CH_WIDTH'(i));

    nco_channel #(
      .N  (N),
      .ZW (Z_CORR_WIDTH),
      .DW (DFTW_WIDTH),
      .OW (OUTPUT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .load_sync (sync),
      .run       (run[i]),
      .wr_ftw    (op_ftw && hit),
      .wr_dftw   (op_dftw && hit),
      .z_corr    (op_z && hit),
      .ph_set    (op_set && hit),
      .data      (cmd.cmd_data),
      .phase_msb (phase_out[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
    );
  end

endmodule

// File: doc/nco_bank.md
# nco_bank

Multi-channel numerically controlled oscillator bank that generalises the single-channel NCO to NUM_CH independent phase accumulators behind one shared command port. Each channel supports a base frequency tuning word (FTW), a linear FTW ramp (chirp), one-shot signed virtual-Z phase corrections and direct phase loads. A global sync re-aligns all channels. The block sits between the pulse sequencer, which issues commands, and the per-channel phase-to-amplitude lookup, which consumes `phase_out`.

## Interface
- N, 22: phase and FTW width in bits.
- NUM_CH, 4: number of channels, at least 2.
- Z_CORR_WIDTH, 12: signed virtual-Z correction width, at most N.
- DFTW_WIDTH, 12: signed FTW ramp-step width, at most N.
- OUTPUT_WIDTH, 10: phase MSBs per channel driven to the output, at most N.
- CH_WIDTH: derived, $clog2(NUM_CH); not overridable.

Ports:
- clk, in, 1: single clock; every register is clocked on its rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: the bank accepts a command when both cmd_valid and cmd_ready are high at a clock edge.
- cmd_op, in, 3: opcode.
- cmd_ch, in, CH_WIDTH: target channel.
- cmd_data, in, N: command payload.
- run, in, NUM_CH: per-channel FTW advance enable.
- sync, in, 1: global phase/ramp realignment request.
- phase_out, out, NUM_CH*OUTPUT_WIDTH: channel i occupies bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH], taken from the phase MSBs.
- phase_valid, out, NUM_CH: phase_out slice i is valid for the downstream lookup.

## Operation
- Per-channel state: ftw_base[N], ftw_cur[N], dftw[DFTW_WIDTH] (signed), phase[N].
- Opcodes:
  - 0 WR_FTW: ftw_base and ftw_cur both load cmd_data.
  - 1 WR_DFTW: dftw loads cmd_data[DFTW_WIDTH-1:0].
  - 2 Z_CORR: one-shot phase add of z = cmd_data[Z_CORR_WIDTH-1:0], signed.
  - 3 PHASE_SET: phase loads cmd_data.
  - 4–7: accepted with no effect.
- Per-channel update at each edge while in IDLE:
  - phase <= phase + (run[i] ? ftw_cur : 0) + (zc_hit ? sext(z) << (N−Z_CORR_WIDTH) : 0), modulo 2^N.
  - zc_hit is true when a Z_CORR command to channel i is accepted at that edge.
  - The virtual-Z add applies whether run[i] is high or low.
- Ramp: when run[i] is high, ftw_cur <= ftw_cur + sext(dftw), modulo 2^N. The phase add in the same edge uses the pre-update ftw_cur.
- Priority within one edge for one channel:
  - PHASE_SET overrides the run and Z_CORR terms.
  - WR_FTW overrides the ramp step.
- FSM has two states:
  - IDLE: normal operation; transitions to SYNC when sync is high at an edge.
  - SYNC: lasts exactly one cycle and always returns to IDLE. In this cycle, every phase is 0 and every ftw_cur equals ftw_base; the values are loaded on the entry edge and held through the cycle regardless of run.
  - If sync is still high on the exit edge, the FSM re-enters SYNC.
- cmd_ready = (state == IDLE) && !sync. No command is accepted on an edge that enters SYNC.
- phase_valid[i] is a register loaded with run[i] && (state == IDLE) && !sync.
- Reset (asynchronous, active-low): all state registers and phase_valid go to 0 and the FSM goes to IDLE, so phase_out is 0. cmd_ready becomes 1 once rst is released and sync is low. Reset asserted mid-ramp or mid-SYNC clears immediately.

## Timing
- A command accepted at edge k takes effect at edge k; phase_out reflects it after edge k, giving 1-cycle latency.
- run[i] sampled at edge k advances phase at edge k; phase_valid[i] rises after edge k.
- sync high at edge k forces phase_out to 0 after edge k. The first advance happens at edge k+1 if sync has dropped.
- All outputs are registered, except cmd_ready, which is combinational from the FSM state and sync.

## Structure
- Package nco_pkg holds the opcode localparams (OP_WR_FTW=0, OP_WR_DFTW=1, OP_Z_CORR=2, OP_PHASE_SET=3) and the FSM state encoding (ST_IDLE, ST_SYNC).
- Sub-module nco_channel holds one channel's registers, adders and priority logic, and is instantiated NUM_CH times through a generate loop. The top level holds the FSM, command decode and output packing.

## Test plan
All scenarios use default parameters.
1. Reset then WR_FTW ch0 = 0x040000 with run[0]=1:
   - ch0 phase_out rises by 64 per cycle and wraps 960→0 after 16 advances.
   - All other slices stay at 0.
2. Z_CORR ch1 = 0x400 with run[1]=0:
   - ch1 phase_out goes 0→256 once, then holds.
   - Z_CORR = 0x800 then moves it 256→768 (adds −512, modulo 1024).
3. Ramp: WR_FTW ch2 = 0, WR_DFTW = 0x010, run[2]=1:
   - ftw_cur goes 0, 16, 32, …
   - Phase becomes 16·k(k−1)/2 after k advances.
4. sync pulse mid-ramp:
   - The next cycle shows all phase_out = 0, ftw_cur = ftw_base and cmd_ready = 0.
   - A command held valid is accepted only on the following edge.
5. Same edge, ch3: PHASE_SET = 0x100000 while run[3]=1 and FTW ≠ 0 → phase = 0x100000, so phase_out = 256.
6. Assert rst during a ramp, then release:
   - All outputs are 0 immediately.
   - cmd_ready = 1 after release.
   - Ramp does not resume until reprogrammed.
